// File: rtl/signed_sub_with_saturation_pipe.sv
// ---------------------------------------------------------------------------
// signed_sub_with_saturation_pipe
//
// Two-stage valid/ready pipelined signed subtractor. It computes a - b exactly
// at WIDTH+1 bits in stage 1. Stage 2 clamps the result to the WIDTH-bit two's
// complement range and flags which rail was hit. A saturating counter records
// how many clamped results were delivered downstream.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous reset, active-low
//   in_valid      operand pair valid
//   in_ready      block accepts an operand pair this cycle (combinational)
//   a, b          signed minuend / subtrahend (WIDTH bits)
//   out_valid     result valid
//   out_ready     downstream accepts the result
//   diff          saturated a - b (WIDTH bits, signed)
//   sat_pos       result clamped to the positive rail
//   sat_neg       result clamped to the negative rail
//   sat_count     count of clamped results delivered; sticks at all-ones
//   sat_count_clr synchronous clear of sat_count; wins over an increment
// ---------------------------------------------------------------------------
module signed_sub_with_saturation_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             sat_pos,
  output logic             sat_neg,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_count_clr
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [WIDTH:0]   s1_diff;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;
  logic             over_max;
  logic             under_min;

  // Handshake and advance conditions. S2 can take new data whenever it is
  // empty or is being drained this cycle, so full throughput has no bubble.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // One extra bit of headroom makes the subtraction exact.
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};

  // The exact difference is in range iff its two top bits agree. When they
  // disagree, the top bit tells us which rail was crossed.
  assign over_max  = !s1_diff[WIDTH] &&  s1_diff[WIDTH-1];
  assign under_min =  s1_diff[WIDTH] && !s1_diff[WIDTH-1];

  // Stage 1: capture the exact difference on an input handshake. The slot
  // empties when its contents move to S2 and nothing new arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_diff  <= a_ext - b_ext;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: clamp and present. The data only changes when S1 advances, so
  // the outputs hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      sat_pos   <= 1'b0;
      sat_neg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sat_pos <= over_max;
        sat_neg <= under_min;
        if (over_max) begin
          diff <= MAX_VAL;
        end else if (under_min) begin
          diff <= MIN_VAL;
        end else begin
          diff <= s1_diff[WIDTH-1:0];
        end
      end
    end
  end

  // Saturation event counter. It counts only delivered results, so data
  // discarded by reset never contributes. A clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_count_clr) begin
      sat_count <= '0;
    end else if (out_fire && (sat_pos || sat_neg) && (sat_count != CNT_MAX)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// ---------------------------------------------------------------------------
// tb_signed_sub_with_saturation_pipe
//
// Scoreboard bench. The stimulus pushes the expected result when an input
// handshake happens. The monitor peeks at the head while a result is shown
// and pops it on the output handshake. Two instances share the stimulus:
// one has CNT_W=8, the other CNT_W=2 so that counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_signed_sub_with_saturation_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       sat_count_clr;
  logic [3:0] a;
  logic [3:0] b;

  logic       in_ready, out_valid, sat_pos, sat_neg;
  logic [3:0] diff;
  logic [7:0] sat_count;

  logic       in_ready_c, out_valid_c, sat_pos_c, sat_neg_c;
  logic [3:0] diff_c;
  logic [1:0] sat_count_c;

  typedef struct {
    logic signed [3:0] diff;
    logic              pos;
    logic              neg;
  } exp_t;

  exp_t sb[$];
  int   out_log[$];
  exp_t mon_e;
  bit   ohs;
  bit   hold_active = 0;
  int   tests = 0;
  int   fails = 0;
  int   in_flight = 0;
  int   stall_seen = 0;
  int   cnt8 = 0;
  int   cnt2 = 0;
  int   ready_mode = 0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  signed_sub_with_saturation_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .sat_pos(sat_pos), .sat_neg(sat_neg),
    .sat_count(sat_count), .sat_count_clr(sat_count_clr)
  );

  signed_sub_with_saturation_pipe #(.WIDTH(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .a(a), .b(b), .out_valid(out_valid_c), .out_ready(out_ready),
    .diff(diff_c), .sat_pos(sat_pos_c), .sat_neg(sat_neg_c),
    .sat_count(sat_count_c), .sat_count_clr(sat_count_clr)
  );

  // Reference: exact integer subtraction followed by clamping to [-8, 7].
  function automatic exp_t model(input logic signed [3:0] av, input logic signed [3:0] bv);
    int   d;
    exp_t e;
    d = int'(av) - int'(bv);
    e.pos = 1'b0;
    e.neg = 1'b0;
    if (d > 7) begin
      e.diff = 4'sd7;
      e.pos  = 1'b1;
    end else if (d < -8) begin
      e.diff = -4'sd8;
      e.neg  = 1'b1;
    end else begin
      e.diff = d[3:0];
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one operand pair, wait (bounded) for acceptance, and record the
  // expected result in the scoreboard.
  task automatic applyStimulus(input int av, input int bv);
    logic [3:0] at;
    logic [3:0] bt;
    bit         accepted;
    at       = av[3:0];
    bt       = bv[3:0];
    a        = at;
    b        = bt;
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    else sb.push_back(model(at, bt));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && in_flight != 0; i++) @(negedge clk);
    checkOutput("drain_in_flight", in_flight, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    sat_count_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_count_clr = 1'b0;
  endtask

  // Consumer: always ready, random, a counted stall, or fully stalled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
      end
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: checks in_ready against the occupancy model, checks the shown
  // result against the scoreboard head (so stalled data must hold), pops on
  // the output handshake, and tracks the expected counter values.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_active = 0;
    end else begin
      checkOutput("in_ready", int'(in_ready), int'((in_flight < 2) || out_ready));
      checkOutput("in_ready_c", int'(in_ready_c), int'((in_flight < 2) || out_ready));
      if (!in_ready) stall_seen++;
      if (hold_active) checkOutput("hold_out_valid", int'(out_valid), 1);
      checkOutput("sat_count", int'(sat_count), cnt8);
      checkOutput("sat_count_c", int'(sat_count_c), cnt2);
      ohs = out_valid && out_ready;
      mon_e.diff = 4'sd0;
      mon_e.pos = 1'b0;
      mon_e.neg = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          mon_e = sb[0];
          checkOutput("diff", int'($signed(diff)), int'(mon_e.diff));
          checkOutput("sat_pos", int'(sat_pos), int'(mon_e.pos));
          checkOutput("sat_neg", int'(sat_neg), int'(mon_e.neg));
          if (out_valid_c) begin
            checkOutput("diff_c", int'($signed(diff_c)), int'(mon_e.diff));
            checkOutput("sat_flags_c", int'({sat_pos_c, sat_neg_c}), int'({mon_e.pos, mon_e.neg}));
          end
          if (ohs) begin
            void'(sb.pop_front());
            out_log.push_back(int'($signed(diff)));
          end
        end
      end
      if (sat_count_clr) begin
        cnt8 = 0;
        cnt2 = 0;
      end else if (ohs && (mon_e.pos || mon_e.neg)) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
      in_flight = in_flight + int'(in_valid && in_ready) - int'(ohs);
      hold_active = out_valid && !out_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_dir[5];
    int exp_bp[6];
    exp_dir = '{7, -8, -2, 0, -8};
    exp_bp  = '{-1, 0, 1, 2, 3, 4};

    rst_n = 1'b0;
    in_valid = 1'b0;
    sat_count_clr = 1'b0;
    a = 4'd0;
    b = 4'd0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_sat_count", int'(sat_count), 0);
    checkOutput("rst_diff", int'(diff), 0);
    checkOutput("rst_flags", int'({sat_pos, sat_neg}), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed clamping and exact cases.
    out_log.delete();
    applyStimulus(7, -8);
    applyStimulus(-8, 1);
    applyStimulus(3, 5);
    applyStimulus(-8, -8);
    applyStimulus(-1, 7);
    waitDrain();
    checkOutput("dir_count_len", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      checkOutput("dir_diff_hand", out_log[i], exp_dir[i]);
    checkOutput("dir_sat_count", int'(sat_count), 2);

    // Backpressure: 4-cycle stall mid-stream.
    out_log.delete();
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        stall_cnt = 4;
        ready_mode = 2;
      end
      applyStimulus(i, 1);
    end
    waitDrain();
    ready_mode = 0;
    checkOutput("bp_in_ready_dropped", int'(stall_seen > 0), 1);
    checkOutput("bp_len", out_log.size(), 6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      checkOutput("bp_diff_hand", out_log[i], exp_bp[i]);

    // Counter saturation, then clear coinciding with a saturating handshake.
    pulseClear();
    for (int i = 0; i < 5; i++) applyStimulus(7, -8);
    waitDrain();
    checkOutput("cnt_sticks_c", int'(sat_count_c), 3);
    checkOutput("cnt_five", int'(sat_count), 5);
    applyStimulus(-8, 7);
    @(posedge clk);
    #1;
    pulseClear();
    waitDrain();
    checkOutput("clr_priority", int'(sat_count), 0);
    checkOutput("clr_priority_c", int'(sat_count_c), 0);

    // Random stress.
    ready_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    ready_mode = 0;
    waitDrain();
    checkOutput("rand_sat_count", int'(sat_count), cnt8);

    // Reset with two items in flight.
    ready_mode = 3;
    @(posedge clk);
    #1;
    applyStimulus(6, -5);
    applyStimulus(-7, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", int'(out_valid), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 1);
    checkOutput("mid_rst_sat_count", int'(sat_count), 0);
    sb.delete();
    in_flight = 0;
    cnt8 = 0;
    cnt2 = 0;
    out_log.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    applyStimulus(2, 5);
    waitDrain();
    checkOutput("post_rst_len", out_log.size(), 1);
    if (out_log.size() > 0) checkOutput("post_rst_first", out_log[0], -3);
    checkOutput("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
